siso_alpha_recursion: RTL and testbench
=======================================

Name: siso_alpha_recursion

Overview:
- Downstream consumer of the branch-metric stage in the SISO (max-log-MAP) decoder for the LTE 8-state RSC code (g0 = 1+D^2+D^3 feedback, g1 = 1+D+D^3).
- Takes the two branch metrics per trellis step and runs the forward (alpha) state-metric recursion with add-compare-select (ACS) and normalisation.
- Emits per step the 8 alpha metrics paired with that step, for the later beta/LLR stage.

Parameters:
- GW, 16, branch-metric input width (signed)
- AW, 18, state-metric width (signed)
- LW, 13, block-length width (LTE K up to 6144)

Ports:
- clk  in  1  clock
- rst  in  1  reset, synchronous, active-high
- valid_in  in  1  one trellis step presented this cycle
- sof_in  in  1  qualifies valid_in: first step of a block
- blklen  in  LW  number of steps in block; sampled on valid_in&sof_in
- gamma1_in  in  GW  signed metric for (u,p)=(0,0); (1,1) uses -gamma1
- gamma2_in  in  GW  signed metric for (u,p)=(0,1); (1,0) uses -gamma2
- alpha_out  out  8*AW  alpha_k, state s at bits [s*AW +: AW]
- valid_out  out  1  alpha_out valid
- eof_out  out  1  with valid_out on last step of block
- err_out  out  1  one-cycle protocol-error pulse

Behaviour:
- Clock, reset: one clock, clk. Reset is synchronous and active-high (rst). Reset is sampled only on the clk edge.
- Reset values:
  - valid_out, eof_out, err_out = 0
  - alpha_out = 0
  - FSM = IDLE, step counter = 0
  - alpha register = INIT
- INIT: s0 = 0, s1..s7 = NEG_INF = -(2^(AW-2)).
- Trellis definition:
  - State s = 4*d1 + 2*d2 + d3.
  - Input u gives feedback a = u^d2^d3 and parity p = a^d1^d3.
  - Next state = 4*a + 2*d1 + d2.
  - Bit 0 maps to +metric.
- Gamma mapping, with g1/g2 sign-extended to AW:
  - (0,0) = +g1
  - (0,1) = +g2
  - (1,0) = -g2
  - (1,1) = -g1
- ACS: for each s', new(s') = max over the two (s,u) into s' of alpha(s) + gamma(u,p). Additions saturate at AW.
- Normalisation: out(s') = new(s') - new(0), saturated to AW, then floored at NEG_INF. State 0 is always 0 after the first step.
- Latency: 1 cycle. On an accepted valid_in for step k:
  - next cycle valid_out=1 and alpha_out = alpha_k (the metric *before* gamma_k);
  - alpha register <= alpha_{k+1}.
- On sof steps, alpha_k = INIT regardless of register contents.
- FSM:
  - IDLE: valid_in&sof_in: accept step 0, capture blklen, count = 1. Go to RUN if blklen > 1, else stay IDLE with eof_out.
  - IDLE: valid_in without sof_in: ignored, err_out pulse.
  - RUN: valid_in&!sof_in: accept, count++. When the accepted step index == blklen-1, eof_out=1 with its output and FSM -> IDLE.
  - RUN: valid_in&sof_in: abort current block, err_out pulse, restart as step 0 (INIT) with new blklen. No eof for the aborted block.
  - RUN: valid_in=0: hold state. Gaps are allowed. Outputs deassert next cycle.
- blklen = 0 at sof: treated as 1.
- Reset mid-block: the block is discarded with no eof. The first post-reset output requires sof.
- Simultaneous rst and valid_in: rst wins.

Decomposition:
- siso_pkg holds:
  - NUM_STATES = 8
  - NEG_INF(AW)
  - functions next_state(s,u) and parity(s,u)
  - sat_add / sat_sub helpers
  - state-metric vector typedef
- One sub-module: siso_alpha_acs, one ACS node with two candidates, max and saturation. It is instantiated 8 times through generate over s'; predecessors are derived from the package functions.
- The FSM, counter and normalisation stay in the top.

Test Plan:
- Reset then sof, blklen=4, g1=10, g2=4 -> cycle+1: alpha_out = {0, NEG_INF x7}, valid_out=1. The next step output has s0=0, s4=-20, all others NEG_INF.
- blklen=4 with four steps of g1=g2=0, contiguous -> four valid_out pulses with eof_out only on the 4th. The FSM then ignores a non-sof valid_in and pulses err_out.
- Random gammas, blklen=40, random valid gaps -> alpha_out bit-exact against the package-based reference model. State 0 is 0 on every step after the first.
- sof at step 2 of a blklen=10 block -> err_out pulse. The output after that sof equals INIT and no eof is issued for the aborted block. The new block's eof arrives after 10 accepted steps.
- Extreme gammas ±32767 for 100 steps -> no wrap-around. All metrics stay in [NEG_INF, 2^(AW-1)-1] and the saturation paths are hit (coverage).
- rst asserted mid-block together with valid_in -> next cycle valid_out=0. Following sof block output matches a fresh run.

Source files
------------

// File: rtl/siso_pkg.sv
// Shared types, constants and trellis helpers for the SISO alpha recursion
// of the LTE 8-state RSC code (feedback 1+D^2+D^3, parity 1+D+D^3).
package siso_pkg;

  localparam int NUM_STATES = 8;
  localparam int SM_W       = 18;

  typedef logic signed [SM_W-1:0] sm_t;
  typedef sm_t sm_vec_t [NUM_STATES];

  typedef enum logic {IDLE, RUN} fsm_state_t;

  // -(2^(SM_W-2)): far enough below zero to mark unreachable states while
  // leaving headroom so adding a branch metric never wraps.
  localparam sm_t NEG_INF = {2'b11, {(SM_W-2){1'b0}}};
  localparam sm_t SM_MAX  = {1'b0, {(SM_W-1){1'b1}}};
  localparam sm_t SM_MIN  = {1'b1, {(SM_W-1){1'b0}}};

  // State s = 4*d1 + 2*d2 + d3; feedback a = u^d2^d3; next = 4*a + 2*d1 + d2.
  function automatic int next_state(input int s, input int u);
    int d1, d2, d3, a;
    d1 = (s >> 2) & 1;
    d2 = (s >> 1) & 1;
    d3 = s & 1;
    a  = u ^ d2 ^ d3;
    return 4 * a + 2 * d1 + d2;
  endfunction

  // Parity p = a ^ d1 ^ d3.
  function automatic int parity(input int s, input int u);
    int d1, d2, d3, a;
    d1 = (s >> 2) & 1;
    d2 = (s >> 1) & 1;
    d3 = s & 1;
    a  = u ^ d2 ^ d3;
    return a ^ d1 ^ d3;
  endfunction

  // idx-th (0 or 1) branch entering state sp, encoded as 2*s + u.
  function automatic int pred_state(input int sp, input int idx);
    int n, r;
    n = 0;
    r = 0;
    for (int s = 0; s < NUM_STATES; s++) begin
      for (int u = 0; u < 2; u++) begin
        if (next_state(s, u) == sp) begin
          if (n == idx) r = 2 * s + u;
          n++;
        end
      end
    end
    return r;
  endfunction

  function automatic sm_t sat_add(input sm_t a, input sm_t b);
    logic signed [SM_W:0] s;
    s = {a[SM_W-1], a} + {b[SM_W-1], b};
    if (s[SM_W] != s[SM_W-1]) return s[SM_W] ? SM_MIN : SM_MAX;
    return s[SM_W-1:0];
  endfunction

  function automatic sm_t sat_sub(input sm_t a, input sm_t b);
    logic signed [SM_W:0] s;
    s = {a[SM_W-1], a} - {b[SM_W-1], b};
    if (s[SM_W] != s[SM_W-1]) return s[SM_W] ? SM_MIN : SM_MAX;
    return s[SM_W-1:0];
  endfunction

  // Branch metric for (u,p): (0,0)=+g1, (0,1)=+g2, (1,0)=-g2, (1,1)=-g1.
  function automatic sm_t gamma_of(input sm_t g1, input sm_t g2, input int u, input int p);
    if (u == 0) return (p == 0) ? g1 : g2;
    return (p == 0) ? sat_sub('0, g2) : sat_sub('0, g1);
  endfunction

  // Start-of-block metrics: encoder starts in state 0.
  function automatic sm_t init_metric(input int s);
    return (s == 0) ? sm_t'(0) : NEG_INF;
  endfunction

endpackage

// File: rtl/siso_alpha_acs.sv
// One add-compare-select node: two saturating candidates, keep the larger.
module siso_alpha_acs
  import siso_pkg::*;
#(
  parameter int AW = SM_W
) (
  input  logic signed [AW-1:0] alpha_a,
  input  logic signed [AW-1:0] gamma_a,
  input  logic signed [AW-1:0] alpha_b,
  input  logic signed [AW-1:0] gamma_b,
  output logic signed [AW-1:0] metric
);

  sm_t cand_a, cand_b;

  // Add each branch metric to its predecessor and select the survivor.
  always_comb begin
    cand_a = sat_add(alpha_a, gamma_a);
    cand_b = sat_add(alpha_b, gamma_b);
    metric = (cand_a >= cand_b) ? cand_a : cand_b;
  end

endmodule

// File: rtl/siso_alpha_recursion.sv
// Forward (alpha) state-metric recursion for the max-log-MAP SISO decoder.
// Each accepted step outputs alpha_k one cycle later and updates the
// internal register to the normalised alpha_{k+1}.
module siso_alpha_recursion
  import siso_pkg::*;
#(
  parameter int GW = 16,
  parameter int AW = SM_W,
  parameter int LW = 13
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         valid_in,
  input  logic                         sof_in,
  input  logic [LW-1:0]                blklen,
  input  logic [GW-1:0]                gamma1_in,
  input  logic [GW-1:0]                gamma2_in,
  output logic [NUM_STATES*AW-1:0]     alpha_out,
  output logic                         valid_out,
  output logic                         eof_out,
  output logic                         err_out
);

  fsm_state_t    state_reg, state_next;
  logic [LW-1:0] count_reg, count_next;
  logic [LW-1:0] blklen_reg, blklen_next, blklen_eff;
  logic          valid_out_reg, valid_out_next;
  logic          eof_out_reg, eof_out_next;
  logic          err_out_reg, err_out_next;
  logic          accept;

  sm_vec_t alpha_reg, alpha_out_reg, alpha_k, alpha_new, alpha_norm;
  sm_t     g1_ext, g2_ext;

  assign g1_ext     = {{(AW-GW){gamma1_in[GW-1]}}, gamma1_in};
  assign g2_ext     = {{(AW-GW){gamma2_in[GW-1]}}, gamma2_in};
  assign blklen_eff = (blklen == '0) ? LW'(1) : blklen;

  generate
    for (genvar gi = 0; gi < NUM_STATES; gi++) begin : g_state
      localparam int PA = pred_state(gi, 0);
      localparam int PB = pred_state(gi, 1);

      // A start-of-block step always begins from the known zero state.
      assign alpha_k[gi] = sof_in ? init_metric(gi) : alpha_reg[gi];

      siso_alpha_acs #(.AW(AW)) u_acs (
        .alpha_a (alpha_k[PA >> 1]),
        .gamma_a (gamma_of(g1_ext, g2_ext, PA & 1, parity(PA >> 1, PA & 1))),
        .alpha_b (alpha_k[PB >> 1]),
        .gamma_b (gamma_of(g1_ext, g2_ext, PB & 1, parity(PB >> 1, PB & 1))),
        .metric  (alpha_new[gi])
      );

      // Normalise against state 0 and floor so metrics cannot drift low.
      assign alpha_norm[gi] = (sat_sub(alpha_new[gi], alpha_new[0]) < NEG_INF)
                              ? NEG_INF : sat_sub(alpha_new[gi], alpha_new[0]);

      assign alpha_out[gi*AW +: AW] = alpha_out_reg[gi];
    end
  endgenerate

  assign valid_out = valid_out_reg;
  assign eof_out   = eof_out_reg;
  assign err_out   = err_out_reg;

  // Block framing: accept steps, count them, flag end of block and protocol errors.
  always_comb begin
    state_next     = state_reg;
    count_next     = count_reg;
    blklen_next    = blklen_reg;
    eof_out_next   = 1'b0;
    err_out_next   = 1'b0;
    accept         = 1'b0;
    if (valid_in) begin
      if (sof_in) begin
        accept       = 1'b1;
        err_out_next = (state_reg == RUN);
        blklen_next  = blklen_eff;
        count_next   = LW'(1);
        if (blklen_eff > LW'(1)) begin
          state_next = RUN;
        end else begin
          state_next   = IDLE;
          eof_out_next = 1'b1;
        end
      end else if (state_reg == RUN) begin
        accept     = 1'b1;
        count_next = count_reg + LW'(1);
        if (count_reg == blklen_reg - LW'(1)) begin
          eof_out_next = 1'b1;
          state_next   = IDLE;
        end
      end else begin
        err_out_next = 1'b1;
      end
    end
    valid_out_next = accept;
  end

  // State, counters, output registers and the alpha recursion register.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg     <= IDLE;
      count_reg     <= '0;
      blklen_reg    <= '0;
      valid_out_reg <= 1'b0;
      eof_out_reg   <= 1'b0;
      err_out_reg   <= 1'b0;
      for (int i = 0; i < NUM_STATES; i++) begin
        alpha_reg[i]     <= init_metric(i);
        alpha_out_reg[i] <= '0;
      end
    end else begin
      state_reg     <= state_next;
      count_reg     <= count_next;
      blklen_reg    <= blklen_next;
      valid_out_reg <= valid_out_next;
      eof_out_reg   <= eof_out_next;
      err_out_reg   <= err_out_next;
      if (accept) begin
        alpha_out_reg <= alpha_k;
        alpha_reg     <= alpha_norm;
      end
    end
  end

endmodule

// File: tb/tb_siso_alpha_recursion.sv
// Self-checking bench for siso_alpha_recursion: table vectors, directed
// corner sequences and randomized blocks against a behavioural trellis model.
module tb_siso_alpha_recursion;

  localparam int GW   = 16;
  localparam int AW   = 18;
  localparam int LW   = 13;
  localparam int NS   = 8;
  localparam int NEG  = -65536;
  localparam int MAXV = 131071;
  localparam int MINV = -131072;

  logic              clk = 1'b0;
  logic              rst, valid_in, sof_in;
  logic [LW-1:0]     blklen;
  logic [GW-1:0]     gamma1_in, gamma2_in;
  logic [NS*AW-1:0]  alpha_out;
  logic              valid_out, eof_out, err_out;

  always #5 clk = ~clk;

  siso_alpha_recursion #(.GW(GW), .AW(AW), .LW(LW)) dut (
    .clk       (clk),
    .rst       (rst),
    .valid_in  (valid_in),
    .sof_in    (sof_in),
    .blklen    (blklen),
    .gamma1_in (gamma1_in),
    .gamma2_in (gamma2_in),
    .alpha_out (alpha_out),
    .valid_out (valid_out),
    .eof_out   (eof_out),
    .err_out   (err_out)
  );

  int checks = 0;
  int errors = 0;

  // Reference model state
  int  m_alpha[NS];
  int  m_ak[NS];
  bit  m_run;
  int  m_cnt, m_len;
  logic [NS*AW-1:0] exp_alpha, init_vec;
  bit  exp_v, exp_e, exp_r;
  int  exp_idx;

  typedef struct {
    bit v; bit sof; int bl; int g1; int g2;
    bit ev; bit ee; bit er;
  } vec_t;
  vec_t tbl[8];

  function automatic int clamp(input int x);
    if (x > MAXV) return MAXV;
    if (x < MINV) return MINV;
    return x;
  endfunction

  function automatic int rg();
    return int'($urandom_range(0, 65535)) - 32768;
  endfunction

  task automatic chk(input string nm, input logic [NS*AW-1:0] act, input logic [NS*AW-1:0] expv);
    checks++;
    if (act !== expv) begin
      errors++;
      $display("FAIL %s: got %h expected %h", nm, act, expv);
    end
  endtask

  // One trellis step straight from the code definition, on m_ak -> m_alpha.
  task automatic model_trellis(input int g1, input int g2);
    int nw[NS];
    int d1, d2, d3, a, p, nx, gm, c, o;
    for (int s = 0; s < NS; s++) nw[s] = -100000000;
    for (int s = 0; s < NS; s++) begin
      for (int u = 0; u < 2; u++) begin
        d1 = (s >> 2) & 1; d2 = (s >> 1) & 1; d3 = s & 1;
        a  = u ^ d2 ^ d3;
        p  = a ^ d1 ^ d3;
        nx = 4 * a + 2 * d1 + d2;
        if (u == 0) gm = (p == 0) ? g1 : g2;
        else        gm = (p == 0) ? -g2 : -g1;
        c = clamp(m_ak[s] + gm);
        if (c > nw[nx]) nw[nx] = c;
      end
    end
    for (int s = 0; s < NS; s++) begin
      o = clamp(nw[s] - nw[0]);
      if (o < NEG) o = NEG;
      m_alpha[s] = o;
    end
  endtask

  // Drive one cycle, advance the model, then check outputs after the edge.
  task automatic cyc(input bit r, input bit v, input bit s, input int bl, input int g1, input int g2);
    bit acc;
    int idx;
    rst = r; valid_in = v; sof_in = s;
    blklen = bl[LW-1:0]; gamma1_in = g1[GW-1:0]; gamma2_in = g2[GW-1:0];
    exp_v = 0; exp_e = 0; exp_r = 0; acc = 0; idx = 0;
    if (r) begin
      m_run = 0; m_cnt = 0;
      for (int i = 0; i < NS; i++) m_alpha[i] = (i == 0) ? 0 : NEG;
    end else if (v) begin
      if (s) begin
        exp_r = m_run;
        m_len = (bl == 0) ? 1 : bl;
        for (int i = 0; i < NS; i++) m_ak[i] = (i == 0) ? 0 : NEG;
        acc = 1; idx = 0;
      end else if (m_run) begin
        m_ak = m_alpha;
        acc = 1; idx = m_cnt;
      end else begin
        exp_r = 1;
      end
      if (acc) begin
        exp_v = 1;
        for (int i = 0; i < NS; i++) exp_alpha[i*AW +: AW] = AW'(m_ak[i]);
        model_trellis(g1, g2);
        m_cnt = idx + 1;
        exp_e = (idx == m_len - 1);
        m_run = !exp_e;
      end
    end
    exp_idx = idx;
    @(posedge clk);
    #1;
    chk("valid_out", valid_out, exp_v);
    chk("eof_out", eof_out, exp_e);
    chk("err_out", err_out, exp_r);
    if (exp_v) chk("alpha_out", alpha_out, exp_alpha);
    if (r) chk("alpha_out_rst", alpha_out, '0);
  endtask

  initial begin
    logic [NS*AW-1:0] v4;
    logic signed [AW-1:0] x;
    int k;

    for (int i = 0; i < NS; i++) init_vec[i*AW +: AW] = (i == 0) ? AW'(0) : AW'(NEG);

    rst = 1; valid_in = 0; sof_in = 0; blklen = '0; gamma1_in = '0; gamma2_in = '0;
    cyc(1, 0, 0, 0, 0, 0);
    cyc(1, 1, 1, 4, 5, 5);

    // Sof with g1=10, g2=4: INIT first, then s0=0, s4=-20, rest NEG_INF.
    cyc(0, 1, 1, 4, 10, 4);
    chk("t1_init", alpha_out, init_vec);
    cyc(0, 1, 0, 0, 10, 4);
    v4 = init_vec;
    v4[4*AW +: AW] = AW'(-20);
    chk("t1_step1", alpha_out, v4);
    cyc(0, 1, 0, 0, 10, 4);
    cyc(0, 1, 0, 0, 10, 4);
    cyc(0, 0, 0, 0, 0, 0);

    // Table: four zero-gamma steps, stray valid, then blklen 0 and 1 blocks.
    tbl[0] = '{1, 1, 4, 0, 0, 1, 0, 0};
    tbl[1] = '{1, 0, 0, 0, 0, 1, 0, 0};
    tbl[2] = '{1, 0, 0, 0, 0, 1, 0, 0};
    tbl[3] = '{1, 0, 0, 0, 0, 1, 1, 0};
    tbl[4] = '{1, 0, 0, 0, 0, 0, 0, 1};
    tbl[5] = '{0, 0, 0, 0, 0, 0, 0, 0};
    tbl[6] = '{1, 1, 0, 7, 3, 1, 1, 0};
    tbl[7] = '{1, 1, 1, -7, 9, 1, 1, 0};
    for (int i = 0; i < 8; i++) begin
      cyc(0, tbl[i].v, tbl[i].sof, tbl[i].bl, tbl[i].g1, tbl[i].g2);
      chk("tbl_valid", valid_out, tbl[i].ev);
      chk("tbl_eof", eof_out, tbl[i].ee);
      chk("tbl_err", err_out, tbl[i].er);
    end

    // Random gammas, blklen 40, random gaps.
    cyc(0, 1, 1, 40, rg(), rg());
    k = 1;
    for (int c = 0; c < 2000 && k < 40; c++) begin
      if ($urandom_range(0, 9) < 7) begin
        cyc(0, 1, 0, 0, rg(), rg());
        chk("s0_zero", alpha_out[AW-1:0], '0);
        k++;
      end else begin
        cyc(0, 0, 0, 0, rg(), rg());
      end
    end
    cyc(0, 0, 0, 0, 0, 0);

    // Abort with sof at step 2 of a blklen 10 block.
    cyc(0, 1, 1, 10, rg(), rg());
    cyc(0, 1, 0, 0, rg(), rg());
    cyc(0, 1, 1, 10, rg(), rg());
    chk("abort_err", err_out, 1'b1);
    chk("abort_init", alpha_out, init_vec);
    for (int i = 0; i < 9; i++) cyc(0, 1, 0, 0, rg(), rg());
    chk("abort_new_eof", eof_out, 1'b1);

    // Extreme gammas, 100 steps: no wrap, metrics stay within range.
    cyc(0, 1, 1, 100, 32767, -32767);
    for (int i = 1; i < 100; i++) begin
      cyc(0, 1, 0, 0, ($urandom_range(0, 1) != 0) ? 32767 : -32767,
                      ($urandom_range(0, 1) != 0) ? 32767 : -32767);
      for (int s = 0; s < NS; s++) begin
        x = alpha_out[s*AW +: AW];
        chk("range_lo", (x < NEG) ? 1'b1 : 1'b0, 1'b0);
      end
    end

    // Reset mid-block together with valid_in; then a fresh block.
    cyc(0, 1, 1, 10, 100, -50);
    cyc(0, 1, 0, 0, 200, 30);
    cyc(0, 1, 0, 0, -70, 90);
    cyc(1, 1, 0, 0, 11, 22);
    cyc(0, 1, 0, 0, 11, 22);
    cyc(0, 1, 1, 3, 100, -50);
    chk("post_rst_init", alpha_out, init_vec);
    cyc(0, 1, 0, 0, 200, 30);
    cyc(0, 1, 0, 0, -70, 90);
    cyc(0, 0, 0, 0, 0, 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
